// File: rtl/serial_seq_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// serial_seq_gen : MSB-first serial frame generator fed by a host or auto sweep
// Rev 1.0
// -----------------------------------------------------------------------------
module serial_seq_gen #(
  parameter int WIDTH      = 8,
  parameter int GAP        = 4,
  parameter int AUTO_START = 47,
  parameter int AUTO_STEP  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             auto_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       frame_cnt,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] shreg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CW-1:0]    BIT_LOAD = CW'(WIDTH - 1);
  localparam logic [GW-1:0]    GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [WIDTH-1:0] START_V  = WIDTH'(AUTO_START);
  localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(AUTO_STEP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    bit_cnt_n;
  logic [GW-1:0]    gap_cnt;
  logic [GW-1:0]    gap_cnt_n;
  logic [WIDTH-1:0] shreg_n;
  logic [WIDTH-1:0] auto_val;
  logic [WIDTH-1:0] auto_val_n;
  logic             frame_done_n;
  logic [7:0]       frame_cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state  <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      auto_val   <= START_V;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      cur_state  <= nxt_state;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      auto_val   <= auto_val_n;
      frame_done <= frame_done_n;
      frame_cnt  <= frame_cnt_n;
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    shreg_n      = shreg;
    bit_cnt_n    = bit_cnt;
    gap_cnt_n    = gap_cnt;
    auto_val_n   = auto_val;
    frame_done_n = 1'b0;
    frame_cnt_n  = frame_cnt;

    case (cur_state)
      ST_IDLE: begin
        // Auto mode owns the line whenever enabled; host words wait.
        if (auto_en) begin
          shreg_n    = auto_val;
          auto_val_n = auto_val + STEP_V;
          bit_cnt_n  = BIT_LOAD;
          nxt_state  = ST_SHIFT;
        end else if (in_valid) begin
          shreg_n   = in_data;
          bit_cnt_n = BIT_LOAD;
          nxt_state = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        shreg_n   = shreg << 1;
        bit_cnt_n = bit_cnt - 1'b1;
        if (bit_cnt == '0) begin
          bit_cnt_n    = '0;
          frame_done_n = 1'b1;
          frame_cnt_n  = frame_cnt + 8'd1;
          if (GAP > 0) begin
            gap_cnt_n = GAP_LOAD;
            nxt_state = ST_GAP;
          end else begin
            nxt_state = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt == '0) begin
          nxt_state = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt - 1'b1;
        end
      end

      default: nxt_state = ST_IDLE;
    endcase
  end

  assign state      = cur_state;
  assign dout_valid = (cur_state == ST_SHIFT);
  assign dout       = (cur_state == ST_SHIFT) ? shreg[WIDTH-1] : 1'b0;
  assign busy       = (cur_state != ST_IDLE);
  assign in_ready   = (cur_state == ST_IDLE) && !auto_en;

endmodule
`default_nettype wire

// File: tb/tb_serial_seq_gen.sv
`default_nettype none
// tb_serial_seq_gen: table vectors, hand-written corner sequences and a
// randomized frame-offset reference model for serial_seq_gen.
module tb_serial_seq_gen;

  localparam int W = 8;
  localparam int G = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, auto_en;
  logic [7:0] in_data;
  logic       in_ready, dout, dout_valid, busy, frame_done;
  logic [7:0] frame_cnt, shreg;
  logic [1:0] state;

  logic       in_valid_b, auto_en_b;
  logic [7:0] in_data_b;
  logic       in_ready_b, dout_b, dout_valid_b, busy_b, frame_done_b;
  logic [7:0] frame_cnt_b, shreg_b;
  logic [1:0] state_b;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc_g  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  serial_seq_gen #(.WIDTH(8), .GAP(4), .AUTO_START(47), .AUTO_STEP(64)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .auto_en(auto_en), .dout(dout), .dout_valid(dout_valid), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .state(state), .shreg(shreg)
  );

  serial_seq_gen #(.WIDTH(8), .GAP(0), .AUTO_START(47), .AUTO_STEP(64)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .auto_en(auto_en_b), .dout(dout_b), .dout_valid(dout_valid_b), .busy(busy_b),
    .frame_done(frame_done_b), .frame_cnt(frame_cnt_b), .state(state_b), .shreg(shreg_b)
  );

  typedef struct {
    bit         a;
    logic [7:0] d;
    logic [7:0] w;
    bit         hold;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; auto_en = 1'b0; in_valid_b = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_outputs", {busy, dout, dout_valid, frame_done, frame_cnt}, 0);
    chk("rst_shreg", shreg, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  // One frame on dut_a, from an IDLE cycle to the next IDLE cycle (offset W+G).
  task automatic run_frame(input bit a, input logic [7:0] d, input logic [7:0] w,
                           input int exp_cnt, input bit hold, input int abort_at,
                           output int acc);
    int k;
    logic [7:0] sx;
    acc = -1;
    auto_en  = a;
    in_valid = 1'b1;
    in_data  = a ? 8'hFF : d;
    k = 0;
    do begin
      step();
      k++;
    end while (!dout_valid && k < 40);
    if (!dout_valid) begin
      chk("accept_timeout", dout_valid, 1);
      return;
    end
    acc = cyc_g;
    chk("accept_latency", k, 1);
    if (!a && !hold) in_valid = 1'b0;
    if (!a) in_data = ~d;
    for (int t = 0; t < W; t++) begin
      if (t == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_state", state, 0);
        chk("abort_dout", dout, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cnt", frame_cnt, 0);
        auto_en = 1'b0;
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
          step();
          chk("abort_no_done", frame_done, 0);
        end
        rst = 1'b0;
        return;
      end
      sx = w << t;
      chk("dout_bit", dout, w[W-1-t]);
      chk("dout_valid", dout_valid, 1);
      chk("shreg", shreg, sx);
      chk("ready_in_frame", in_ready, 0);
      step();
    end
    chk("frame_done", frame_done, 1);
    chk("frame_cnt", frame_cnt, exp_cnt[7:0]);
    for (int t = W; t < W + G; t++) begin
      if (t > W) chk("frame_done_clear", frame_done, 0);
      chk("gap_dout", {dout, dout_valid}, 0);
      chk("gap_state", {state, busy}, {2'd2, 1'b1});
      chk("gap_ready", in_ready, 0);
      step();
    end
    chk("idle_state", {state, busy}, 0);
    chk("idle_ready", in_ready, !a);
    chk("idle_cnt", frame_cnt, exp_cnt[7:0]);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[8];
    int         acc_a[8];
    int         acc;
    int         k;
    int         fd_cyc[$];
    logic [7:0] wa, wb, d;
    // reference model state (frame offset based)
    int         cyc, off, m_start, m_cnt, m_auto;
    bit         m_active, e_dv, e_dout, e_fd, idle;
    logic [1:0] e_state;
    logic [7:0] m_word;

    tbl[0] = '{1'b0, 8'd47,  8'd47,  1'b0};
    tbl[1] = '{1'b0, 8'd111, 8'd111, 1'b1};
    tbl[2] = '{1'b0, 8'd175, 8'd175, 1'b0};
    tbl[3] = '{1'b1, 8'd0,   8'd47,  1'b0};
    tbl[4] = '{1'b1, 8'd0,   8'd111, 1'b0};
    tbl[5] = '{1'b1, 8'd0,   8'd175, 1'b0};
    tbl[6] = '{1'b1, 8'd0,   8'd239, 1'b0};
    tbl[7] = '{1'b1, 8'd0,   8'd47,  1'b0};

    rst = 1'b1; in_valid = 1'b0; auto_en = 1'b0; in_data = 8'd0;
    in_valid_b = 1'b0; auto_en_b = 1'b0; in_data_b = 8'd0;
    #19;
    chk("init_state", state, 0);
    chk("init_outputs", {busy, dout, dout_valid, frame_done, frame_cnt}, 0);
    chk("init_shreg", shreg, 0);
    chk("init_ready", in_ready, 1);
    chk("init_b", {state_b, busy_b, dout_b, frame_cnt_b, shreg_b}, 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // host words, back-to-back host words, then the auto sweep with wrap
    for (int i = 0; i < 8; i++)
      run_frame(tbl[i].a, tbl[i].d, tbl[i].w, i + 1, tbl[i].hold, -1, acc_a[i]);
    auto_en = 1'b0;
    in_valid = 1'b0;
    chk("spacing_0_1", acc_a[1] - acc_a[0], 13);
    chk("spacing_held", acc_a[2] - acc_a[1], 13);

    // GAP=0 instance: A5 then 5A back to back
    wa = 8'hA5;
    wb = 8'h5A;
    in_valid_b = 1'b1;
    in_data_b  = wa;
    k = 0;
    do begin
      step();
      k++;
    end while (!dout_valid_b && k < 40);
    chk("b_accept", dout_valid_b, 1);
    in_data_b = wb;
    for (int t = 0; t < 18; t++) begin
      if (frame_done_b) fd_cyc.push_back(cyc_g);
      if (t < 8) begin
        chk("b_bit", {dout_valid_b, dout_b}, {1'b1, wa[7-t]});
        chk("b_done_low", frame_done_b, 0);
      end else if (t == 8 || t == 17) begin
        chk("b_idle", {dout_valid_b, dout_b, frame_done_b, state_b, busy_b}, 6'b001000);
        chk("b_idle_ready", in_ready_b, 1);
      end else begin
        chk("b_bit", {dout_valid_b, dout_b}, {1'b1, wb[7-(t-9)]});
        chk("b_done_low", frame_done_b, 0);
        in_valid_b = 1'b0;
      end
      step();
    end
    chk("b_cnt", frame_cnt_b, 2);
    chk("b_pulses", fd_cyc.size(), 2);
    if (fd_cyc.size() == 2) chk("b_pulse_spacing", fd_cyc[1] - fd_cyc[0], 9);

    // reset while the 4th bit of 175 is shifting, then auto restarts at 47
    do_reset();
    run_frame(1'b1, 8'd0, 8'd47,  1, 1'b0, -1, acc);
    run_frame(1'b1, 8'd0, 8'd111, 2, 1'b0, -1, acc);
    run_frame(1'b1, 8'd0, 8'd175, 0, 1'b0, 3,  acc);
    run_frame(1'b1, 8'd0, 8'd47,  1, 1'b0, -1, acc);
    auto_en = 1'b0;

    // frame counter wrap over 256 host frames
    do_reset();
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      run_frame(1'b0, d, d, (i + 1) % 256, 1'b0, -1, acc);
    end

    // randomized traffic against a frame-offset reference model
    do_reset();
    m_active = 1'b0; m_start = 0; m_word = 8'd0; m_cnt = 0; m_auto = 47; cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      off     = cyc - m_start;
      e_dv    = m_active && off < W;
      e_dout  = 1'b0;
      if (e_dv) e_dout = m_word[W-1-off];
      e_fd    = m_active && off == W;
      e_state = (!m_active || off >= W + G) ? 2'd0 : ((off < W) ? 2'd1 : 2'd2);
      chk("rand_outputs", {state, busy, dout_valid, dout, frame_done, frame_cnt},
          {e_state, e_state != 2'd0, e_dv, e_dout, e_fd, 8'(m_cnt)});
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #1;
        chk("rand_reset", {state, busy, dout_valid, dout, frame_done, frame_cnt}, 0);
        step();
        rst = 1'b0;
        cyc++;
        m_active = 1'b0; m_cnt = 0; m_auto = 47;
        continue;
      end
      if ($urandom_range(0, 24) == 0) auto_en = ~auto_en;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      #1;
      idle = (e_state == 2'd0);
      chk("rand_ready", in_ready, idle && !auto_en);
      if (idle && auto_en) begin
        m_word = 8'(m_auto);
        m_auto = (m_auto + 64) % 256;
        m_active = 1'b1;
        m_start = cyc + 1;
      end else if (idle && in_valid) begin
        m_word = in_data;
        m_active = 1'b1;
        m_start = cyc + 1;
      end
      step();
      cyc++;
      if (m_active && (cyc - m_start) == W) m_cnt = (m_cnt + 1) % 256;
    end
    auto_en = 1'b0;
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_seq_gen.md
Name: serial_seq_gen

Overview:
Serial test-sequence generator. It is the transmit side for the team's serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake, or self-generates an arithmetic sweep.
- Shifts each word out MSB first, one bit per clock, on a single-bit line, with a configurable idle gap between frames.
- Used on the bench and on the board to drive the detector's din input.

Parameters:
WIDTH, 8, frame length in bits and width of data path.
GAP, 4, idle cycles (dout=0) after each frame; 0 allowed.
AUTO_START, 47, first word emitted in auto mode.
AUTO_STEP, 64, increment between auto-mode words, modulo 2^WIDTH.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  host word valid.
in_data  in  WIDTH  host word.
in_ready  out  1  high when state==IDLE and auto_en==0; combinational.
auto_en  in  1  auto-sweep mode enable.
dout  out  1  serial bit; shreg[WIDTH-1] when state==SHIFT, else 0.
dout_valid  out  1  high when state==SHIFT.
busy  out  1  high when state!=IDLE.
frame_done  out  1  registered one-cycle pulse after the last bit of a frame.
frame_cnt  out  8  completed-frame counter, wraps 255->0.
state  out  2  IDLE=0, SHIFT=1, GAP=2.
shreg  out  WIDTH  current shift register contents.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; shreg=0, bit_cnt=0, gap_cnt=0, frame_done=0, frame_cnt=0, auto_val=AUTO_START.
  - dout=0 and dout_valid=0 as soon as rst rises.
- IDLE:
  - If auto_en=1 at an edge: shreg<=auto_val, auto_val<=auto_val+AUTO_STEP (mod 2^WIDTH), bit_cnt<=WIDTH-1, go to SHIFT.
  - Else if in_valid && in_ready: shreg<=in_data, bit_cnt<=WIDTH-1, go to SHIFT.
  - auto_en has priority; in_ready=0 whenever auto_en=1.
  - in_valid while in_ready=0 is ignored; the host holds it.
- SHIFT:
  - Each edge: shreg<=shreg<<1 (zero fill), bit_cnt decrements.
  - Timing: accept at edge k; bit WIDTH-1 is on dout during cycle k..k+1; bit 0 is on dout during cycle k+WIDTH-1..k+WIDTH. The consumer samples on the following edge.
  - At edge k+WIDTH (bit_cnt==0):
    - go to GAP (gap_cnt<=GAP-1) if GAP>0, else go to IDLE;
    - frame_done<=1 for exactly one cycle;
    - frame_cnt increments.
- GAP: dout=0; gap_cnt decrements each edge; at gap_cnt==0 go to IDLE.
- Minimum spacing between frame starts: WIDTH+GAP+1 cycles; IDLE always lasts at least 1 cycle.
- auto_en is sampled only in IDLE. Deasserting it mid-frame lets the frame complete. auto_val persists across auto_en toggles and is cleared only by rst.
- in_data is captured only at the accept edge; later changes have no effect on the frame in flight.
- Reset mid-frame aborts the frame with no frame_done pulse and no frame_cnt increment. After release, the next frame starts fresh at bit WIDTH-1.
- frame_cnt wraps 255->0 with no flag.

Test Plan:
1. Default parameters, rst high 20 ns then low; in_valid=1, in_data=47 for one accepted edge:
   - dout over next 8 cycles = 0,0,1,0,1,1,1,1, with dout_valid high for exactly those 8 cycles;
   - frame_done pulses on the 9th cycle; frame_cnt=1;
   - dout=0 for 4 gap cycles; in_ready returns high after 13 cycles.
2. Host words 111 then 175 with in_valid held continuously:
   - second accept occurs exactly 13 cycles after the first;
   - streams are 01101111 and 10101111;
   - in_ready is low for the whole gap; frame_cnt=2.
3. auto_en=1 for 5 frames:
   - emitted words are 47, 111, 175, 239, 47 (239+64 wraps to 47);
   - in_ready stays 0 throughout, even with in_valid=1 and in_data=0xFF.
4. Assert rst while the 4th bit of 175 is shifting:
   - state=0, dout=0, busy=0 immediately; no frame_done; frame_cnt unchanged at reset value 0;
   - after release, auto mode restarts at 47.
5. GAP=0 instance, back-to-back host words 0xA5, 0x5A:
   - dout = 10100101, then one 0 idle cycle, then 01011010;
   - frame_done pulses twice, 9 cycles apart.
6. 256 host frames:
   - frame_cnt reads 255 after the 255th frame_done and 0 after the 256th;
   - no other output disturbed.
